// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (CPU / debug loader) arbiter in front of an
// asynchronous 16-bit SRAM. It takes one transaction at a time and holds the
// SRAM strobes for WAIT_CYCLES access cycles. When both ports request in the
// same cycle, the port that was not granted last wins.
//
// Ports
//   Clk, Reset                 system clock, async active-low reset
//   cpu_req/we/addr/wdata      CPU transaction request (req held until done)
//   dbg_req/we/addr/wdata      debug/loader transaction request
//   cpu_done, dbg_done         one-cycle completion pulses
//   rdata                      data of the last completed read
//   busy                       high whenever a transaction is in flight
//   CE, OE, WE, UB, LB         active-low SRAM strobes
//   ADDR, Data                 SRAM address and bidirectional data bus
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [19:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [19:0] dbg_addr,
   input  logic [15:0] dbg_wdata,
   output logic        cpu_done,
   output logic        dbg_done,
   output logic [15:0] rdata,
   output logic        busy,
   output logic        CE,
   output logic        OE,
   output logic        WE,
   output logic        UB,
   output logic        LB,
   output logic [19:0] ADDR,
   inout  wire  [15:0] Data
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // r_last_dbg doubles as the owner of the transaction in flight
   logic                r_last_dbg;
   logic                r_we_lat;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rdata;

   logic                r_ce_n;
   logic                r_oe_n;
   logic                r_we_n;
   logic                r_drive;
   logic                r_cpu_done;
   logic                r_dbg_done;
   logic                r_busy;

   logic                w_gnt;
   logic                w_gnt_dbg;
   logic                w_we_nxt;
   logic                w_acc_nxt;
   logic                w_done_nxt;
   logic                w_capture;

   // State register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, grant decision and next-cycle strobe intent
   always_comb begin
      w_state_nxt = r_state;
      w_gnt       = 1'b0;
      w_gnt_dbg   = r_last_dbg;
      w_capture   = 1'b0;

      case (r_state)
         IDLE: begin
            if (cpu_req && dbg_req) begin
               w_gnt     = 1'b1;
               w_gnt_dbg = ~r_last_dbg;
            end else if (cpu_req) begin
               w_gnt     = 1'b1;
               w_gnt_dbg = 1'b0;
            end else if (dbg_req) begin
               w_gnt     = 1'b1;
               w_gnt_dbg = 1'b1;
            end
            if (w_gnt) begin
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = DONE;
               w_capture   = ~r_we_lat;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Direction of the transaction that will be on the bus next cycle
      if (w_gnt) begin
         w_we_nxt = w_gnt_dbg ? dbg_we : cpu_we;
      end else begin
         w_we_nxt = r_we_lat;
      end

      w_acc_nxt  = (w_state_nxt == ACCESS);
      w_done_nxt = (w_state_nxt == DONE);
   end

   // Transaction fields, wait counter and read-data capture
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_last_dbg <= 1'b1;
         r_we_lat   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_cnt      <= '0;
         r_rdata    <= '0;
      end else begin
         if (w_gnt) begin
            r_last_dbg <= w_gnt_dbg;
            r_we_lat   <= w_gnt_dbg ? dbg_we    : cpu_we;
            r_addr     <= w_gnt_dbg ? dbg_addr  : cpu_addr;
            r_wdata    <= w_gnt_dbg ? dbg_wdata : cpu_wdata;
            r_cnt      <= '0;
         end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_capture) begin
            r_rdata <= Data;
         end
      end
   end

   // Registered strobes, bus enable, done pulses and busy
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_ce_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_drive    <= 1'b0;
         r_cpu_done <= 1'b0;
         r_dbg_done <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_ce_n     <= ~w_acc_nxt;
         r_oe_n     <= ~(w_acc_nxt & ~w_we_nxt);
         r_we_n     <= ~(w_acc_nxt & w_we_nxt);
         r_drive    <= w_acc_nxt & w_we_nxt;
         // Only ACCESS leads to DONE, so the owner is already in r_last_dbg
         r_cpu_done <= w_done_nxt & ~r_last_dbg;
         r_dbg_done <= w_done_nxt & r_last_dbg;
         r_busy     <= (w_state_nxt != IDLE);
      end
   end

   assign CE       = r_ce_n;
   assign UB       = r_ce_n;
   assign LB       = r_ce_n;
   assign OE       = r_oe_n;
   assign WE       = r_we_n;
   assign ADDR     = r_addr;
   assign rdata    = r_rdata;
   assign cpu_done = r_cpu_done;
   assign dbg_done = r_dbg_done;
   assign busy     = r_busy;

   // Bus is driven only during write access cycles
   assign Data = r_drive ? r_wdata : 'z;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: transaction-level reference model plus
// directed scenarios and randomized request traffic.
module tb_sram_arbiter;

   localparam int W = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [19:0] cpu_addr, dbg_addr;
   logic [15:0] cpu_wdata, dbg_wdata;
   logic        cpu_done, dbg_done, busy, CE, OE, WE, UB, LB;
   logic [15:0] rdata;
   logic [19:0] ADDR;
   tri1  [15:0] w_data;

   // Extra builds for access-length checks (index 0: WAIT=1, 1: WAIT=15)
   logic [1:0]  x_req;
   logic [1:0]  x_done, x_ddone, x_busy, x_ce, x_oe, x_we, x_ub, x_lb;
   logic [15:0] x_rdata0, x_rdata1;
   logic [19:0] x_addr0, x_addr1;
   tri1  [15:0] x_data0, x_data1;
   logic        x_zero1;
   logic [19:0] x_zero20;
   logic [15:0] x_zero16;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   always #5 Clk = ~Clk;

   sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .cpu_done(cpu_done), .dbg_done(dbg_done), .rdata(rdata), .busy(busy),
      .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .ADDR(ADDR), .Data(w_data)
   );

   sram_arbiter #(.WAIT_CYCLES(1)) u_w1 (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(x_req[0]), .cpu_we(x_zero1), .cpu_addr(x_zero20), .cpu_wdata(x_zero16),
      .dbg_req(x_zero1), .dbg_we(x_zero1), .dbg_addr(x_zero20), .dbg_wdata(x_zero16),
      .cpu_done(x_done[0]), .dbg_done(x_ddone[0]), .rdata(x_rdata0), .busy(x_busy[0]),
      .CE(x_ce[0]), .OE(x_oe[0]), .WE(x_we[0]), .UB(x_ub[0]), .LB(x_lb[0]),
      .ADDR(x_addr0), .Data(x_data0)
   );

   sram_arbiter #(.WAIT_CYCLES(15)) u_w15 (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(x_req[1]), .cpu_we(x_zero1), .cpu_addr(x_zero20), .cpu_wdata(x_zero16),
      .dbg_req(x_zero1), .dbg_we(x_zero1), .dbg_addr(x_zero20), .dbg_wdata(x_zero16),
      .cpu_done(x_done[1]), .dbg_done(x_ddone[1]), .rdata(x_rdata1), .busy(x_busy[1]),
      .CE(x_ce[1]), .OE(x_oe[1]), .WE(x_we[1]), .UB(x_ub[1]), .LB(x_lb[1]),
      .ADDR(x_addr1), .Data(x_data1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, want, $time);
      end
   endtask

   function automatic logic [15:0] mem_init(input logic [19:0] a);
      return a[15:0] ^ {12'h000, a[19:16]} ^ 16'h5A3C;
   endfunction

   // ---------------- SRAM environment (drives bus on reads, stores writes)
   logic [15:0] sram [logic [19:0]];
   logic [15:0] env_q = 16'h0000;

   assign w_data = (!CE && !OE) ? env_q : 16'bz;

   always @(posedge Clk) begin
      if (!CE && !WE) sram[ADDR] = w_data;
      #2;
      env_q = sram.exists(ADDR) ? sram[ADDR] : mem_init(ADDR);
   end

   // ---------------- Reference model: one transaction = W access cycles + 1 done cycle
   logic [15:0] m_mem [logic [19:0]];
   logic        m_active, m_dbg, m_last_dbg, m_we;
   int          m_age;
   logic [19:0] m_addr;
   logic [15:0] m_wdata, m_rdata;

   function automatic logic [15:0] m_rd(input logic [19:0] a);
      return m_mem.exists(a) ? m_mem[a] : mem_init(a);
   endfunction

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_active = 1'b0; m_age = 0; m_last_dbg = 1'b1; m_dbg = 1'b0;
         m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      end else if (m_active) begin
         if (m_age == W) begin
            m_active = 1'b0;
         end else begin
            if (m_we) m_mem[m_addr] = m_wdata;
            else if (m_age == W - 1) m_rdata = m_rd(m_addr);
            m_age++;
         end
      end else if (cpu_req || dbg_req) begin
         m_dbg      = (cpu_req && dbg_req) ? ~m_last_dbg : dbg_req;
         m_last_dbg = m_dbg;
         m_we       = m_dbg ? dbg_we    : cpu_we;
         m_addr     = m_dbg ? dbg_addr  : cpu_addr;
         m_wdata    = m_dbg ? dbg_wdata : cpu_wdata;
         m_active   = 1'b1;
         m_age      = 0;
      end
   end

   // ---------------- Per-cycle comparison against the model
   logic        c_acc, c_dn;
   logic [15:0] c_data;
   always @(negedge Clk) begin
      if (chk_en) begin
         c_acc  = m_active && (m_age < W);
         c_dn   = m_active && (m_age == W);
         c_data = !c_acc ? 16'hFFFF : (m_we ? m_wdata : m_rd(m_addr));
         chk("CE", 32'(CE), 32'(!c_acc));
         chk("UB", 32'(UB), 32'(!c_acc));
         chk("LB", 32'(LB), 32'(!c_acc));
         chk("OE", 32'(OE), 32'(!(c_acc && !m_we)));
         chk("WE", 32'(WE), 32'(!(c_acc && m_we)));
         chk("ADDR", 32'(ADDR), 32'(m_addr));
         chk("busy", 32'(busy), 32'(m_active));
         chk("cpu_done", 32'(cpu_done), 32'(c_dn && !m_dbg));
         chk("dbg_done", 32'(dbg_done), 32'(c_dn && m_dbg));
         chk("rdata", 32'(rdata), 32'(m_rdata));
         chk("Data", 32'(w_data), 32'(c_data));
      end
   end

   function automatic logic [19:0] rand_addr();
      logic [19:0] a;
      a = 20'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a = a | 20'hABC00;
      return a;
   endfunction

   task automatic run_x(input int idx, input int w);
      int ce_lo, done_k, done_n;
      ce_lo = 0; done_k = 0; done_n = 0;
      @(negedge Clk); #1;
      x_req[idx] = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clk);
         if (!x_ce[idx]) ce_lo++;
         if (x_done[idx]) begin
            done_n++;
            if (done_k == 0) done_k = k;
            #1 x_req[idx] = 1'b0;
         end
      end
      chk($sformatf("wait%0d_access_len", w), 32'(ce_lo), 32'(w));
      chk($sformatf("wait%0d_done_cycle", w), 32'(done_k), 32'(w + 1));
      chk($sformatf("wait%0d_done_count", w), 32'(done_n), 32'd1);
      chk($sformatf("wait%0d_rdata", w), 32'(idx == 0 ? x_rdata0 : x_rdata1), 32'h0000FFFF);
   endtask

   initial begin
      int ce_lo, we_lo, done_k, done_n, busy_n, n;
      int at [4];
      logic [3:0] who;

      Reset = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      x_req = '0; x_zero1 = 1'b0; x_zero20 = '0; x_zero16 = '0;
      sram[20'h00014] = 16'h1234;
      m_mem[20'h00014] = 16'h1234;

      repeat (3) @(negedge Clk);
      chk("reset_strobes", 32'({CE, OE, WE, UB, LB}), 32'h1F);
      chk("reset_busy_done", 32'({busy, cpu_done, dbg_done}), 32'h0);
      chk("reset_rdata", 32'(rdata), 32'h0);
      chk("reset_addr", 32'(ADDR), 32'h0);
      chk("reset_data_hiz", 32'(w_data), 32'hFFFF);
      #1 Reset = 1'b1;
      chk_en = 1'b1;

      // CPU read of a preloaded word
      @(negedge Clk); #1;
      cpu_we = 1'b0; cpu_addr = 20'h00014; cpu_req = 1'b1;
      ce_lo = 0; done_k = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge Clk);
         if (!CE && !OE) ce_lo++;
         if (cpu_done) begin
            if (done_k == 0) done_k = k;
            #1 cpu_req = 1'b0;
         end
      end
      chk("t_read_access_cycles", 32'(ce_lo), 32'd2);
      chk("t_read_done_cycle", 32'(done_k), 32'd3);
      chk("t_read_rdata", 32'(rdata), 32'h1234);

      // Debug write: bus driven only while WE is low
      @(negedge Clk); #1;
      dbg_we = 1'b1; dbg_addr = 20'h00055; dbg_wdata = 16'h007F; dbg_req = 1'b1;
      we_lo = 0; done_n = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge Clk);
         if (!WE) begin
            we_lo++;
            chk("t_write_data_driven", 32'(w_data), 32'h007F);
         end else begin
            chk("t_write_data_hiz", 32'(w_data), 32'hFFFF);
         end
         if (dbg_done) begin
            done_n++;
            #1 dbg_req = 1'b0;
         end
      end
      chk("t_write_we_cycles", 32'(we_lo), 32'd2);
      chk("t_write_done_count", 32'(done_n), 32'd1);
      chk("t_write_rdata_kept", 32'(rdata), 32'h1234);

      // CPU request withdrawn in the first access cycle
      @(negedge Clk); #1;
      cpu_we = 1'b0; cpu_addr = 20'h00020; cpu_req = 1'b1;
      done_k = 0; busy_n = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clk);
         if (k == 1) #1 cpu_req = 1'b0;
         if (cpu_done && done_k == 0) done_k = k;
         if (k >= 5 && busy) busy_n++;
      end
      chk("t_drop_done_cycle", 32'(done_k), 32'd3);
      chk("t_drop_no_regrant", 32'(busy_n), 32'd0);
      chk("t_drop_rdata", 32'(rdata), 32'(mem_init(20'h00020)));

      // Reset in the second access cycle of a write
      @(negedge Clk); #1;
      dbg_we = 1'b1; dbg_addr = 20'h00066; dbg_wdata = 16'h1111; dbg_req = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      #1 Reset = 1'b0; dbg_req = 1'b0;
      #1;
      chk("t_rst_strobes", 32'({CE, OE, WE, UB, LB}), 32'h1F);
      chk("t_rst_busy", 32'(busy), 32'h0);
      chk("t_rst_done", 32'({cpu_done, dbg_done}), 32'h0);
      chk("t_rst_data_hiz", 32'(w_data), 32'hFFFF);
      @(negedge Clk); #1 Reset = 1'b1;
      done_n = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge Clk);
         if (cpu_done || dbg_done) done_n++;
      end
      chk("t_rst_no_done", 32'(done_n), 32'd0);

      // Simultaneous requests right after reset: round-robin order
      @(negedge Clk); #1 Reset = 1'b0;
      @(negedge Clk); #1 Reset = 1'b1;
      cpu_we = 1'b0; cpu_addr = 20'h00014;
      dbg_we = 1'b0; dbg_addr = 20'h00055;
      cpu_req = 1'b1; dbg_req = 1'b1;
      n = 0; who = '0;
      for (int i = 0; i < 4; i++) at[i] = 0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge Clk);
         if ((cpu_done || dbg_done) && n < 4) begin
            who[n] = dbg_done;
            at[n]  = k;
            n++;
            if (n == 4) begin
               #1 cpu_req = 1'b0; dbg_req = 1'b0;
            end
         end
      end
      chk("t_rr_count", 32'(n), 32'd4);
      chk("t_rr_order", 32'(who), 32'b1010);
      chk("t_rr_first", 32'(at[0]), 32'd3);
      chk("t_rr_gap1", 32'(at[1] - at[0]), 32'd4);
      chk("t_rr_gap2", 32'(at[2] - at[1]), 32'd4);
      chk("t_rr_gap3", 32'(at[3] - at[2]), 32'd4);

      // Randomized traffic, including one asynchronous reset
      for (int i = 0; i < 400; i++) begin
         @(negedge Clk); #1;
         cpu_req   = ($urandom_range(0, 3) != 0);
         dbg_req   = ($urandom_range(0, 3) != 0);
         cpu_we    = 1'($urandom_range(0, 1));
         dbg_we    = 1'($urandom_range(0, 1));
         cpu_addr  = rand_addr();
         dbg_addr  = rand_addr();
         cpu_wdata = 16'($urandom);
         dbg_wdata = 16'($urandom);
         if (i == 200) Reset = 1'b0;
         if (i == 203) Reset = 1'b1;
      end
      @(negedge Clk); #1;
      cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (6) @(negedge Clk);

      // Access length at the extremes of WAIT_CYCLES
      run_x(0, 1);
      run_x(1, 15);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
